// File: rtl/tlv5618a_pkg.sv
// ============================================================================
// Module   : tlv5618a_pkg
// Purpose  : Shared constants, state type and word builder for the
//            TLV5618A channel scheduler.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package tlv5618a_pkg;

    localparam logic [1:0] CMD_B_BUF = 2'b00;
    localparam logic [1:0] CMD_BUF   = 2'b01;
    localparam logic [1:0] CMD_A_UPD = 2'b10;

    localparam int R1  = 15;
    localparam int SPD = 14;
    localparam int PWR = 13;
    localparam int R0  = 12;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_START   = 3'd1,
        S_WAIT_HI = 3'd2,
        S_WAIT_LO = 3'd3,
        S_GAP     = 3'd4
    } state_t;

    function automatic logic [15:0] build_word(input logic [1:0]  i_cmd,
                                               input logic        i_spd,
                                               input logic        i_pwr,
                                               input logic [11:0] i_code);
        logic [15:0] w_word;
        w_word       = 16'd0;
        w_word[R1]   = i_cmd[1];
        w_word[SPD]  = i_spd;
        w_word[PWR]  = i_pwr;
        w_word[R0]   = i_cmd[0];
        w_word[11:0] = i_code;
        return w_word;
    endfunction

endpackage

`default_nettype wire

// File: rtl/tlv5618a_ctrl.sv
// ============================================================================
// Module   : tlv5618a_ctrl
// Purpose  : Schedules DAC A/B updates into TLV5618A words and sequences the
//            serial interface start/busy handshake.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tlv5618a_ctrl
    import tlv5618a_pkg::*;
#(
    parameter int GAP_CYCLES = 4,
    parameter int TIMEOUT    = 255,
    parameter int BUSY_WAIT  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_a,
    input  logic [11:0] data_a,
    input  logic        req_b,
    input  logic [11:0] data_b,
    input  logic        speed,
    input  logic        pwr_dn,
    output logic        ack_a,
    output logic        ack_b,
    output logic        ctrl_busy,
    output logic        err,
    output logic [15:0] dac_data,
    output logic        dac_start,
    input  logic        dac_busy
);

    state_t      r_state;
    logic [15:0] r_cnt;
    logic        r_pend_a, r_pend_b;
    logic [11:0] r_data_a, r_data_b;
    logic [1:0]  r_cmd;
    logic [11:0] r_code;
    logic        r_ack_a, r_ack_b;
    logic        r_pair2;
    logic [11:0] r_pair_code;
    logic        r_err;
    logic [15:0] r_word;

    state_t      w_nxt;
    logic        w_pa, w_pb;
    logic [11:0] w_da, w_db;
    logic        w_sched, w_take_pair2, w_abort;
    logic [1:0]  w_sel_cmd;
    logic [11:0] w_sel_code;
    logic        w_sel_ack_a, w_sel_ack_b, w_sel_pair;
    logic [15:0] w_word;

    // A request in the deciding cycle bypasses the pending registers so that
    // an idle controller starts the frame on the very next cycle.
    assign w_pa = r_pend_a | req_a;
    assign w_pb = r_pend_b | req_b;
    assign w_da = req_a ? data_a : r_data_a;
    assign w_db = req_b ? data_b : r_data_b;

    always_comb begin
        w_sel_cmd   = CMD_A_UPD;
        w_sel_code  = w_da;
        w_sel_ack_a = 1'b1;
        w_sel_ack_b = 1'b0;
        w_sel_pair  = 1'b0;
        if (w_pa && w_pb) begin
            w_sel_cmd   = CMD_BUF;
            w_sel_code  = w_db;
            w_sel_ack_a = 1'b0;
            w_sel_pair  = 1'b1;
        end else if (w_pb) begin
            w_sel_cmd   = CMD_B_BUF;
            w_sel_code  = w_db;
            w_sel_ack_a = 1'b0;
            w_sel_ack_b = 1'b1;
        end
    end

    always_comb begin
        w_nxt        = r_state;
        w_sched      = 1'b0;
        w_take_pair2 = 1'b0;
        w_abort      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_pa || w_pb) begin
                    w_sched = 1'b1;
                    w_nxt   = S_START;
                end
            end
            S_START:   w_nxt = S_WAIT_HI;
            S_WAIT_HI: begin
                if (dac_busy) begin
                    w_nxt = S_WAIT_LO;
                end else if (r_cnt == 16'(BUSY_WAIT - 1)) begin
                    w_abort = 1'b1;
                    w_nxt   = S_GAP;
                end
            end
            S_WAIT_LO: begin
                if (!dac_busy) begin
                    w_nxt = S_GAP;
                end else if (r_cnt == 16'(TIMEOUT)) begin
                    w_abort = 1'b1;
                    w_nxt   = S_GAP;
                end
            end
            S_GAP: begin
                // The last gap cycle doubles as the scheduling decision.
                if (r_cnt == 16'(GAP_CYCLES - 1)) begin
                    if (r_pair2) begin
                        w_take_pair2 = 1'b1;
                        w_nxt        = S_START;
                    end else if (w_pa || w_pb) begin
                        w_sched = 1'b1;
                        w_nxt   = S_START;
                    end else begin
                        w_nxt = S_IDLE;
                    end
                end
            end
            default: w_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_pend_a    <= 1'b0;
            r_pend_b    <= 1'b0;
            r_data_a    <= '0;
            r_data_b    <= '0;
            r_cmd       <= '0;
            r_code      <= '0;
            r_ack_a     <= 1'b0;
            r_ack_b     <= 1'b0;
            r_pair2     <= 1'b0;
            r_pair_code <= '0;
            r_err       <= 1'b0;
            r_word      <= '0;
        end else begin
            r_state <= w_nxt;
            r_cnt   <= (w_nxt != r_state) ? 16'd0 : r_cnt + 16'd1;

            if (w_sched) begin
                r_pend_a <= 1'b0;
                r_pend_b <= 1'b0;
            end else begin
                if (req_a) begin
                    r_pend_a <= 1'b1;
                    r_data_a <= data_a;
                end
                if (req_b) begin
                    r_pend_b <= 1'b1;
                    r_data_b <= data_b;
                end
            end

            if (w_sched) begin
                r_cmd       <= w_sel_cmd;
                r_code      <= w_sel_code;
                r_ack_a     <= w_sel_ack_a;
                r_ack_b     <= w_sel_ack_b;
                r_pair2     <= w_sel_pair;
                r_pair_code <= w_da;
            end else if (w_take_pair2) begin
                r_cmd   <= CMD_A_UPD;
                r_code  <= r_pair_code;
                r_ack_a <= 1'b1;
                r_ack_b <= 1'b1;
                r_pair2 <= 1'b0;
            end

            if (w_abort) begin
                r_err   <= 1'b1;
                r_pair2 <= 1'b0;
            end

            if (r_state == S_START) begin
                r_word <= w_word;
            end
        end
    end

    assign w_word    = build_word(r_cmd, speed, pwr_dn, r_code);
    assign dac_start = (r_state == S_START);
    assign dac_data  = (r_state == S_START) ? w_word : r_word;
    assign ack_a     = (r_state == S_WAIT_LO) && !dac_busy && r_ack_a;
    assign ack_b     = (r_state == S_WAIT_LO) && !dac_busy && r_ack_b;
    assign ctrl_busy = r_pend_a | r_pend_b | (r_state != S_IDLE);
    assign err       = r_err;

endmodule

`default_nettype wire

// File: tb/tb_tlv5618a_ctrl.sv
// ============================================================================
// Module   : tb_tlv5618a_ctrl
// Purpose  : Self-checking bench for tlv5618a_ctrl with a behavioural DAC
//            word/ack model and a scripted serial-interface responder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tlv5618a_ctrl;

    localparam int G  = 4;
    localparam int TO = 255;
    localparam int BW = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_a = 1'b0, req_b = 1'b0;
    logic [11:0] data_a = '0, data_b = '0;
    logic        speed = 1'b0, pwr_dn = 1'b0;
    logic        dac_busy = 1'b0;
    logic        ack_a, ack_b, ctrl_busy, err, dac_start;
    logic [15:0] dac_data;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    tlv5618a_ctrl #(.GAP_CYCLES(G), .TIMEOUT(TO), .BUSY_WAIT(BW)) dut (
        .clk(clk), .rst(rst),
        .req_a(req_a), .data_a(data_a), .req_b(req_b), .data_b(data_b),
        .speed(speed), .pwr_dn(pwr_dn),
        .ack_a(ack_a), .ack_b(ack_b), .ctrl_busy(ctrl_busy), .err(err),
        .dac_data(dac_data), .dac_start(dac_start), .dac_busy(dac_busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Word = R1*2^15 + SPD*2^14 + PWR*2^13 + R0*2^12 + code, cmd = R1R0 as 0..3
    function automatic logic [15:0] exp_word(input int cmd, input logic spd,
                                             input logic pwr, input logic [11:0] code);
        int v;
        v = (cmd / 2) * 32768 + int'(spd) * 16384 + int'(pwr) * 8192
            + (cmd % 2) * 4096 + int'(code);
        return 16'(v);
    endfunction

    task automatic wait_start(output int s_cyc, output bit ok);
        ok = 1'b0;
        s_cyc = 0;
        for (int i = 0; i < 60 && !ok; i++) begin
            @(negedge clk);
            req_a = 1'b0;
            req_b = 1'b0;
            if (dac_start === 1'b1) begin
                ok = 1'b1;
                s_cyc = cyc;
            end
        end
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL start_wait: dac_start not seen within 60 cycles");
        end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 60 && ctrl_busy; i++) @(negedge clk);
    endtask

    // Responds as the serial interface; optionally pulses req_a during busy.
    task automatic serve_frame(input int busy_n, input int inj_n,
                               input logic [11:0] c0, input logic [11:0] c1,
                               output logic [15:0] word, output logic aa,
                               output logic ab, output int s_cyc, output int f_cyc);
        bit ok;
        word = '0; aa = 1'b0; ab = 1'b0; f_cyc = 0;
        wait_start(s_cyc, ok);
        if (!ok) return;
        word = dac_data;
        dac_busy = 1'b1;
        for (int i = 0; i < busy_n; i++) begin
            @(negedge clk);
            n_checks++;
            if (dac_data !== word || ack_a !== 1'b0 || ack_b !== 1'b0) begin
                n_fail++;
                $display("FAIL busy_phase: data=%h acks=%b%b want data=%h acks=00",
                         dac_data, ack_a, ack_b, word);
            end
            req_a  = (i < inj_n);
            data_a = (i == 0) ? c0 : c1;
        end
        @(negedge clk);
        req_a = 1'b0;
        dac_busy = 1'b0;
        #1;
        aa = ack_a;
        ab = ack_b;
        f_cyc = cyc;
    endtask

    task automatic test_reset();
        #2 rst = 1'b0;
        #1;
        n_checks++;
        if ({dac_start, ack_a, ack_b, ctrl_busy, err, dac_data} !== 21'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b want all zero",
                     {dac_start, ack_a, ack_b, ctrl_busy, err, dac_data});
        end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (ctrl_busy !== 1'b0 || dac_start !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: busy=%b start=%b want 0 0", ctrl_busy, dac_start);
        end
    endtask

    task automatic test_midframe();
        logic [15:0] w; logic aa, ab; int s, f, s2, f2, rc;
        wait_idle();
        @(negedge clk);
        speed = 1'b1; pwr_dn = 1'b0; data_b = 12'hABC; req_b = 1'b1; rc = cyc;
        serve_frame(3, 1, 12'hFFF, 12'h000, w, aa, ab, s, f);
        n_checks++;
        if (w !== exp_word(0, 1'b1, 1'b0, 12'hABC) || s != rc + 1 || aa !== 1'b0 || ab !== 1'b1) begin
            n_fail++;
            $display("FAIL b_only: word=%h lat=%0d acks=%b%b want %h 1 01", w, s - rc, aa, ab,
                     exp_word(0, 1'b1, 1'b0, 12'hABC));
        end
        serve_frame(2, 0, 12'h000, 12'h000, w, aa, ab, s2, f2);
        n_checks++;
        if (w !== exp_word(2, 1'b1, 1'b0, 12'hFFF) || s2 - f != G + 1 || aa !== 1'b1 || ab !== 1'b0) begin
            n_fail++;
            $display("FAIL a_after_b: word=%h gap=%0d acks=%b%b want %h %0d 10", w, s2 - f, aa, ab,
                     exp_word(2, 1'b1, 1'b0, 12'hFFF), G + 1);
        end
    endtask

    task automatic test_pair();
        logic [15:0] w; logic aa, ab; int s, f, s2, f2;
        wait_idle();
        @(negedge clk);
        speed = 1'b0; pwr_dn = 1'b0;
        data_a = 12'h123; data_b = 12'h456; req_a = 1'b1; req_b = 1'b1;
        serve_frame(2, 0, 12'h000, 12'h000, w, aa, ab, s, f);
        n_checks++;
        if (w !== exp_word(1, 1'b0, 1'b0, 12'h456) || aa !== 1'b0 || ab !== 1'b0) begin
            n_fail++;
            $display("FAIL pair_first: word=%h acks=%b%b want %h 00", w, aa, ab,
                     exp_word(1, 1'b0, 1'b0, 12'h456));
        end
        serve_frame(2, 0, 12'h000, 12'h000, w, aa, ab, s2, f2);
        n_checks++;
        if (w !== exp_word(2, 1'b0, 1'b0, 12'h123) || s2 - f != G + 1 || aa !== 1'b1 || ab !== 1'b1) begin
            n_fail++;
            $display("FAIL pair_second: word=%h gap=%0d acks=%b%b want %h %0d 11", w, s2 - f, aa, ab,
                     exp_word(2, 1'b0, 1'b0, 12'h123), G + 1);
        end
    endtask

    task automatic test_overwrite();
        logic [15:0] w; logic aa, ab; int s, f, starts;
        wait_idle();
        @(negedge clk);
        speed = 1'b0; pwr_dn = 1'b0; data_b = 12'($urandom); req_b = 1'b1;
        serve_frame(4, 2, 12'h001, 12'h002, w, aa, ab, s, f);
        serve_frame(2, 0, 12'h000, 12'h000, w, aa, ab, s, f);
        n_checks++;
        if (w !== exp_word(2, 1'b0, 1'b0, 12'h002) || aa !== 1'b1 || ab !== 1'b0) begin
            n_fail++;
            $display("FAIL latest_wins: word=%h acks=%b%b want %h 10", w, aa, ab,
                     exp_word(2, 1'b0, 1'b0, 12'h002));
        end
        starts = 0;
        repeat (20) begin
            @(negedge clk);
            if (dac_start === 1'b1 || ack_a === 1'b1) starts++;
        end
        n_checks++;
        if (starts != 0) begin
            n_fail++;
            $display("FAIL single_frame: extra start/ack events=%0d want 0", starts);
        end
    endtask

    task automatic test_busy_wait();
        logic [15:0] w; logic aa, ab; int s, f, e_cyc, acks; bit ok;
        logic [11:0] c;
        wait_idle();
        @(negedge clk);
        data_b = 12'($urandom); req_b = 1'b1;
        wait_start(s, ok);
        e_cyc = -1; acks = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (err === 1'b1 && e_cyc < 0) e_cyc = cyc;
            if (ack_a === 1'b1 || ack_b === 1'b1) acks++;
        end
        n_checks++;
        if (e_cyc != s + BW + 1 || acks != 0) begin
            n_fail++;
            $display("FAIL busy_wait_abort: err_at=%0d acks=%0d want %0d 0", e_cyc - s, acks, BW + 1);
        end
        wait_idle();
        c = 12'($urandom);
        @(negedge clk);
        data_a = c; req_a = 1'b1;
        serve_frame(1, 0, 12'h000, 12'h000, w, aa, ab, s, f);
        n_checks++;
        if (w !== exp_word(2, speed, pwr_dn, c) || aa !== 1'b1 || err !== 1'b1) begin
            n_fail++;
            $display("FAIL after_abort: word=%h ack_a=%b err=%b want %h 1 1", w, aa, err,
                     exp_word(2, speed, pwr_dn, c));
        end
    endtask

    task automatic test_timeout();
        int s, e_cyc, acks; bit ok;
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        n_checks++;
        if (err !== 1'b0) begin
            n_fail++;
            $display("FAIL err_cleared: err=%b want 0", err);
        end
        @(negedge clk);
        data_b = 12'($urandom); req_b = 1'b1;
        wait_start(s, ok);
        dac_busy = 1'b1;
        e_cyc = -1; acks = 0;
        for (int i = 0; i < TO + 20; i++) begin
            @(negedge clk);
            if (err === 1'b1 && e_cyc < 0) e_cyc = cyc;
            if (ack_a === 1'b1 || ack_b === 1'b1) acks++;
        end
        dac_busy = 1'b0;
        repeat (3) @(negedge clk);
        if (ack_a === 1'b1 || ack_b === 1'b1) acks++;
        // busy seen at s+1, then TIMEOUT+1 further high cycles before abort
        n_checks++;
        if (e_cyc != s + TO + 3 || acks != 0) begin
            n_fail++;
            $display("FAIL timeout_abort: err_at=%0d acks=%0d want %0d 0", e_cyc - s, acks, TO + 3);
        end
    endtask

    task automatic test_reset_mid();
        int s, starts; bit ok;
        wait_idle();
        @(negedge clk);
        data_b = 12'($urandom); req_b = 1'b1;
        wait_start(s, ok);
        dac_busy = 1'b1;
        @(negedge clk);
        data_a = 12'($urandom); req_a = 1'b1;
        @(negedge clk);
        req_a = 1'b0;
        rst = 1'b0;
        #1;
        n_checks++;
        if ({dac_start, ack_a, ack_b, ctrl_busy, err, dac_data} !== 21'd0) begin
            n_fail++;
            $display("FAIL reset_mid: got %b want all zero",
                     {dac_start, ack_a, ack_b, ctrl_busy, err, dac_data});
        end
        @(negedge clk);
        rst = 1'b1;
        dac_busy = 1'b0;
        starts = 0;
        repeat (20) begin
            @(negedge clk);
            if (dac_start === 1'b1 || ctrl_busy === 1'b1) starts++;
        end
        n_checks++;
        if (starts != 0) begin
            n_fail++;
            $display("FAIL reset_no_frame: activity cycles=%0d want 0", starts);
        end
    endtask

    task automatic test_random();
        logic [15:0] w; logic aa, ab; int s, f, s2, f2, rc, mask;
        logic [11:0] ca, cb; logic sp, pw;
        for (int it = 0; it < 24; it++) begin
            wait_idle();
            mask = int'($urandom_range(1, 3));
            ca = 12'($urandom); cb = 12'($urandom);
            sp = 1'($urandom); pw = 1'($urandom);
            @(negedge clk);
            speed = sp; pwr_dn = pw; data_a = ca; data_b = cb;
            req_a = mask[0]; req_b = mask[1]; rc = cyc;
            serve_frame(int'($urandom_range(1, 6)), 0, 12'h000, 12'h000, w, aa, ab, s, f);
            n_checks++;
            if (mask == 3) begin
                if (w !== exp_word(1, sp, pw, cb) || s != rc + 1 || aa !== 1'b0 || ab !== 1'b0) begin
                    n_fail++;
                    $display("FAIL rnd_pair1 it=%0d: word=%h lat=%0d acks=%b%b want %h 1 00",
                             it, w, s - rc, aa, ab, exp_word(1, sp, pw, cb));
                end
                sp = 1'($urandom); pw = 1'($urandom);
                speed = sp; pwr_dn = pw;
                serve_frame(int'($urandom_range(1, 6)), 0, 12'h000, 12'h000, w, aa, ab, s2, f2);
                n_checks++;
                if (w !== exp_word(2, sp, pw, ca) || s2 - f != G + 1 || aa !== 1'b1 || ab !== 1'b1) begin
                    n_fail++;
                    $display("FAIL rnd_pair2 it=%0d: word=%h gap=%0d acks=%b%b want %h %0d 11",
                             it, w, s2 - f, aa, ab, exp_word(2, sp, pw, ca), G + 1);
                end
            end else if (mask == 2) begin
                if (w !== exp_word(0, sp, pw, cb) || s != rc + 1 || aa !== 1'b0 || ab !== 1'b1) begin
                    n_fail++;
                    $display("FAIL rnd_b it=%0d: word=%h lat=%0d acks=%b%b want %h 1 01",
                             it, w, s - rc, aa, ab, exp_word(0, sp, pw, cb));
                end
            end else begin
                if (w !== exp_word(2, sp, pw, ca) || s != rc + 1 || aa !== 1'b1 || ab !== 1'b0) begin
                    n_fail++;
                    $display("FAIL rnd_a it=%0d: word=%h lat=%0d acks=%b%b want %h 1 10",
                             it, w, s - rc, aa, ab, exp_word(2, sp, pw, ca));
                end
            end
        end
        wait_idle();
        n_checks++;
        if (err !== 1'b0 || ctrl_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rnd_end: err=%b busy=%b want 0 0", err, ctrl_busy);
        end
    endtask

    initial begin
        test_reset();
        test_midframe();
        test_pair();
        test_overwrite();
        test_random();
        test_busy_wait();
        test_timeout();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
